pe_agu_stream: RTL and testbench

- Parametrised next-generation PE address generation unit. Sits between PE ID and DMEM.
- Adds per-stream pointer registers with post-increment and circular-buffer addressing alongside plain base+offset.
- Generalises byte-lane select and store-data alignment to any DATA_WIDTH.
- Registers all DMEM-side outputs: one cycle of latency, with a stall hold.

---
 rtl/pe_agu_stream_if.sv | 52 +++++
 rtl/pe_agu_stream.sv | 180 ++++++++++++++++++
 tb/tb_pe_agu_stream.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_agu_stream_if.sv
// Request/config/DMEM bundle for pe_agu_stream; master = PE ID side, slave = the AGU.
interface pe_agu_stream_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_STREAMS = 4
);
  localparam int SW = $clog2(NUM_STREAMS);
  localparam int NB = DATA_WIDTH / 8;

  logic                  iStall;
  logic                  iID_AGU_Valid;
  logic [1:0]            iID_AGU_Mode;
  logic [SW-1:0]         iID_AGU_Stream_Sel;
  logic [DATA_WIDTH-1:0] iID_AGU_Operand_A;
  logic [DATA_WIDTH-1:0] iID_AGU_Operand_B;
  logic                  iID_AGU_Memory_Write_Enable;
  logic                  iID_AGU_Memory_Read_Enable;
  logic [1:0]            iID_AGU_Memory_Opcode;
  logic [DATA_WIDTH-1:0] iID_AGU_Memory_Store_Data;
  logic                  iCfg_Write_Enable;
  logic [SW-1:0]         iCfg_Stream_Sel;
  logic [1:0]            iCfg_Field;
  logic [DATA_WIDTH-1:0] iCfg_Data;

  logic                  oAGU_DMEM_Valid;
  logic                  oAGU_DMEM_Memory_Write_Enable;
  logic                  oAGU_DMEM_Memory_Read_Enable;
  logic [NB-1:0]         oAGU_DMEM_Byte_Select;
  logic [1:0]            oAGU_DMEM_Opcode;
  logic [DATA_WIDTH-1:0] oAGU_DMEM_Memory_Store_Data;
  logic [DATA_WIDTH-1:0] oAGU_DMEM_Address;
  logic                  oAGU_Misaligned;

  modport master (
    output iStall, iID_AGU_Valid, iID_AGU_Mode, iID_AGU_Stream_Sel,
           iID_AGU_Operand_A, iID_AGU_Operand_B, iID_AGU_Memory_Write_Enable,
           iID_AGU_Memory_Read_Enable, iID_AGU_Memory_Opcode, iID_AGU_Memory_Store_Data,
           iCfg_Write_Enable, iCfg_Stream_Sel, iCfg_Field, iCfg_Data,
    input  oAGU_DMEM_Valid, oAGU_DMEM_Memory_Write_Enable, oAGU_DMEM_Memory_Read_Enable,
           oAGU_DMEM_Byte_Select, oAGU_DMEM_Opcode, oAGU_DMEM_Memory_Store_Data,
           oAGU_DMEM_Address, oAGU_Misaligned
  );

  modport slave (
    input  iStall, iID_AGU_Valid, iID_AGU_Mode, iID_AGU_Stream_Sel,
           iID_AGU_Operand_A, iID_AGU_Operand_B, iID_AGU_Memory_Write_Enable,
           iID_AGU_Memory_Read_Enable, iID_AGU_Memory_Opcode, iID_AGU_Memory_Store_Data,
           iCfg_Write_Enable, iCfg_Stream_Sel, iCfg_Field, iCfg_Data,
    output oAGU_DMEM_Valid, oAGU_DMEM_Memory_Write_Enable, oAGU_DMEM_Memory_Read_Enable,
           oAGU_DMEM_Byte_Select, oAGU_DMEM_Opcode, oAGU_DMEM_Memory_Store_Data,
           oAGU_DMEM_Address, oAGU_Misaligned
  );
endinterface

// File: rtl/pe_agu_stream.sv
// PE address generation unit: base+offset, post-increment and circular stream pointers, registered DMEM request.
// Optional macro PE_AGU_MISALIGN_TRAP_EN: flag misaligned accesses and suppress their enables.
module pe_agu_stream #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_STREAMS = 4
) (
  input logic            iClk,
  input logic            iReset,
  pe_agu_stream_if.slave bus
);
  localparam int SW = $clog2(NUM_STREAMS);
  localparam int NB = DATA_WIDTH / 8;
  localparam int OW = $clog2(NB);
  localparam logic [1:0] MAX_OP = 2'(OW);

  typedef enum logic [1:0] {
    MODE_BASE_OFF = 2'b00,
    MODE_POST_INC = 2'b01,
    MODE_CIRC     = 2'b10,
    MODE_ALT_BASE = 2'b11
  } agu_mode_e;

  typedef enum logic [1:0] {
    FIELD_BASE   = 2'b00,
    FIELD_STRIDE = 2'b01,
    FIELD_LIMIT  = 2'b10,
    FIELD_PTR    = 2'b11
  } cfg_field_e;

  logic [DATA_WIDTH-1:0] base_q   [NUM_STREAMS];
  logic [DATA_WIDTH-1:0] stride_q [NUM_STREAMS];
  logic [DATA_WIDTH-1:0] limit_q  [NUM_STREAMS];
  logic [DATA_WIDTH-1:0] ptr_q    [NUM_STREAMS];
  logic [DATA_WIDTH-1:0] ptr_d    [NUM_STREAMS];

  logic [SW-1:0]         sel;
  logic                  accept, useStream, ptrUpdate;
  logic [DATA_WIDTH-1:0] curPtr, stepPtr, nextPtr, ea;
  logic [3:0]            nBytes;
  logic [2:0]            sizeMask;
  logic [OW-1:0]         laneOff, alignOff;
  logic [15:0]           laneRun;
  logic [NB-1:0]         laneSel;
  logic [DATA_WIDTH-1:0] storeRep;
  logic                  illegal, misFlag, issueOk;

  logic                  valid_q, valid_d, we_q, we_d, re_q, re_d, mis_q, mis_d;
  logic [NB-1:0]         bs_q, bs_d;
  logic [1:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] data_q, data_d, addr_q, addr_d;

  assign sel       = bus.iID_AGU_Stream_Sel;
  assign accept    = bus.iID_AGU_Valid & ~bus.iStall;
  assign useStream = (bus.iID_AGU_Mode == MODE_POST_INC) || (bus.iID_AGU_Mode == MODE_CIRC);
  assign ptrUpdate = accept & useStream;
  assign curPtr    = ptr_q[sel];
  assign stepPtr   = curPtr + stride_q[sel];
  assign ea        = useStream ? curPtr : bus.iID_AGU_Operand_A + bus.iID_AGU_Operand_B;

  // Circular mode folds the overshoot past limit back onto base.
  always_comb begin
    nextPtr = stepPtr;
    if ((bus.iID_AGU_Mode == MODE_CIRC) && (stepPtr >= limit_q[sel]))
      nextPtr = base_q[sel] + (stepPtr - limit_q[sel]);
  end

  assign nBytes   = 4'd1 << bus.iID_AGU_Memory_Opcode;
  assign sizeMask = nBytes[2:0] - 3'd1;
  assign illegal  = bus.iID_AGU_Memory_Opcode > MAX_OP;
  assign laneOff  = ea[OW-1:0];
  assign alignOff = laneOff & ~sizeMask[OW-1:0];
  assign laneRun  = (16'd1 << nBytes) - 16'd1;
  assign laneSel  = illegal ? '0 : NB'(laneRun << alignOff);

  always_comb begin
    storeRep = '0;
    for (int k = 0; k < NB; k++)
      storeRep[8*k +: 8] = bus.iID_AGU_Memory_Store_Data[8*(k & int'(sizeMask)) +: 8];
  end

`ifdef PE_AGU_MISALIGN_TRAP_EN
  assign misFlag = |(ea[2:0] & sizeMask);
  assign issueOk = ~illegal & ~misFlag;
`else
  assign misFlag = 1'b0;
  assign issueOk = ~illegal;
`endif

  // A config write to a stream overrides any pointer step on that same stream.
  always_comb begin
    for (int i = 0; i < NUM_STREAMS; i++) begin
      ptr_d[i] = ptr_q[i];
      if (bus.iCfg_Write_Enable && (bus.iCfg_Stream_Sel == SW'(i))) begin
        if ((bus.iCfg_Field == FIELD_BASE) || (bus.iCfg_Field == FIELD_PTR))
          ptr_d[i] = bus.iCfg_Data;
      end else if (ptrUpdate && (sel == SW'(i))) begin
        ptr_d[i] = nextPtr;
      end
    end
  end

  always_ff @(posedge iClk or negedge iReset) begin
    if (!iReset) begin
      for (int i = 0; i < NUM_STREAMS; i++) begin
        base_q[i]   <= '0;
        stride_q[i] <= '0;
        limit_q[i]  <= '0;
        ptr_q[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_STREAMS; i++)
        ptr_q[i] <= ptr_d[i];
      if (bus.iCfg_Write_Enable) begin
        case (bus.iCfg_Field)
          FIELD_BASE:   base_q[bus.iCfg_Stream_Sel]   <= bus.iCfg_Data;
          FIELD_STRIDE: stride_q[bus.iCfg_Stream_Sel] <= bus.iCfg_Data;
          FIELD_LIMIT:  limit_q[bus.iCfg_Stream_Sel]  <= bus.iCfg_Data;
          default: ;
        endcase
      end
    end
  end

  // Stall freezes everything; an idle cycle only drops valid and the enables.
  always_comb begin
    valid_d = valid_q;
    we_d    = we_q;
    re_d    = re_q;
    mis_d   = mis_q;
    bs_d    = bs_q;
    op_d    = op_q;
    data_d  = data_q;
    addr_d  = addr_q;
    if (!bus.iStall) begin
      valid_d = accept;
      we_d    = 1'b0;
      re_d    = 1'b0;
      if (accept) begin
        we_d   = bus.iID_AGU_Memory_Write_Enable & issueOk;
        re_d   = bus.iID_AGU_Memory_Read_Enable & issueOk;
        mis_d  = misFlag;
        bs_d   = laneSel;
        op_d   = bus.iID_AGU_Memory_Opcode;
        data_d = storeRep;
        addr_d = ea;
      end
    end
  end

  always_ff @(posedge iClk or negedge iReset) begin
    if (!iReset) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      mis_q   <= 1'b0;
      bs_q    <= '0;
      op_q    <= '0;
      data_q  <= '0;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      we_q    <= we_d;
      re_q    <= re_d;
      mis_q   <= mis_d;
      bs_q    <= bs_d;
      op_q    <= op_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
    end
  end

  assign bus.oAGU_DMEM_Valid               = valid_q;
  assign bus.oAGU_DMEM_Memory_Write_Enable = we_q;
  assign bus.oAGU_DMEM_Memory_Read_Enable  = re_q;
  assign bus.oAGU_DMEM_Byte_Select         = bs_q;
  assign bus.oAGU_DMEM_Opcode              = op_q;
  assign bus.oAGU_DMEM_Memory_Store_Data   = data_q;
  assign bus.oAGU_DMEM_Address             = addr_q;
  assign bus.oAGU_Misaligned               = mis_q;
endmodule

// File: tb/tb_pe_agu_stream.sv
// Self-checking bench for pe_agu_stream (32-bit bus, 4 streams): directed cases plus randomized traffic against a behavioural model.
module tb_pe_agu_stream;
  localparam int DW = 32;
  localparam int NS = 4;
  localparam int NB = DW / 8;

  logic clk  = 1'b0;
  logic rstN = 1'b0;
  int   compared   = 0;
  int   mismatched = 0;
  bit   cmpEn      = 1'b0;

  always #5 clk = ~clk;

  pe_agu_stream_if #(.DATA_WIDTH(DW), .NUM_STREAMS(NS)) bus ();

  pe_agu_stream #(.DATA_WIDTH(DW), .NUM_STREAMS(NS)) dut (
    .iClk   (clk),
    .iReset (rstN),
    .bus    (bus)
  );

  // Behavioural model state: stream registers and the expected registered request.
  logic [DW-1:0] mBase [NS];
  logic [DW-1:0] mStride [NS];
  logic [DW-1:0] mLimit [NS];
  logic [DW-1:0] mPtr [NS];
  logic          expValid, expWe, expRe, expMis;
  logic [NB-1:0] expBs;
  logic [1:0]    expOp;
  logic [DW-1:0] expData, expAddr;

  logic [DW-1:0] mEa, mNext;
  int            mSize, mOff, mSel, mPendIdx;
  bit            mPend, mStream;

  logic [DW-1:0] circExp [5];
  initial circExp = '{32'h40, 32'h44, 32'h48, 32'h4C, 32'h40};

  // The model computes each access from the rules in plain arithmetic at every active edge.
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < NS; i++) begin
        mBase[i] = '0; mStride[i] = '0; mLimit[i] = '0; mPtr[i] = '0;
      end
      expValid = 0; expWe = 0; expRe = 0; expMis = 0;
      expBs = '0; expOp = '0; expData = '0; expAddr = '0;
    end else begin
      mPend = 0;
      mSel = int'(bus.iID_AGU_Stream_Sel);
      mStream = (bus.iID_AGU_Mode == 2'd1) || (bus.iID_AGU_Mode == 2'd2);
      if (bus.iID_AGU_Valid && !bus.iStall) begin
        mEa = mStream ? mPtr[mSel] : bus.iID_AGU_Operand_A + bus.iID_AGU_Operand_B;
        mSize = 1 << bus.iID_AGU_Memory_Opcode;
        expValid = 1;
        expAddr = mEa;
        expOp = bus.iID_AGU_Memory_Opcode;
        for (int k = 0; k < NB; k++)
          expData[8*k +: 8] = bus.iID_AGU_Memory_Store_Data[8*(k % mSize) +: 8];
        expMis = 0;
        if (mSize > NB) begin
          expBs = '0; expWe = 0; expRe = 0;
        end else begin
          mOff = int'(mEa % NB);
          expBs = NB'(((1 << mSize) - 1) << (mOff - (mOff % mSize)));
          expWe = bus.iID_AGU_Memory_Write_Enable;
          expRe = bus.iID_AGU_Memory_Read_Enable;
`ifdef PE_AGU_MISALIGN_TRAP_EN
          if ((mEa % mSize) != 0) begin
            expMis = 1; expWe = 0; expRe = 0;
          end
`endif
        end
        if (mStream) begin
          mNext = mPtr[mSel] + mStride[mSel];
          if (bus.iID_AGU_Mode == 2'd2 && mNext >= mLimit[mSel])
            mNext = mBase[mSel] + (mNext - mLimit[mSel]);
          mPend = 1; mPendIdx = mSel;
        end
      end else if (!bus.iStall) begin
        expValid = 0; expWe = 0; expRe = 0;
      end
      if (mPend && !(bus.iCfg_Write_Enable && int'(bus.iCfg_Stream_Sel) == mPendIdx))
        mPtr[mPendIdx] = mNext;
      if (bus.iCfg_Write_Enable) begin
        case (bus.iCfg_Field)
          2'd0: begin mBase[bus.iCfg_Stream_Sel] = bus.iCfg_Data; mPtr[bus.iCfg_Stream_Sel] = bus.iCfg_Data; end
          2'd1: mStride[bus.iCfg_Stream_Sel] = bus.iCfg_Data;
          2'd2: mLimit[bus.iCfg_Stream_Sel] = bus.iCfg_Data;
          default: mPtr[bus.iCfg_Stream_Sel] = bus.iCfg_Data;
        endcase
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: DUT against model on every falling edge.
  always @(negedge clk) begin
    if (cmpEn) begin
      checkOutput("valid", 64'(bus.oAGU_DMEM_Valid), 64'(expValid));
      checkOutput("we", 64'(bus.oAGU_DMEM_Memory_Write_Enable), 64'(expWe));
      checkOutput("re", 64'(bus.oAGU_DMEM_Memory_Read_Enable), 64'(expRe));
      checkOutput("byteSel", 64'(bus.oAGU_DMEM_Byte_Select), 64'(expBs));
      checkOutput("opcode", 64'(bus.oAGU_DMEM_Opcode), 64'(expOp));
      checkOutput("storeData", 64'(bus.oAGU_DMEM_Memory_Store_Data), 64'(expData));
      checkOutput("address", 64'(bus.oAGU_DMEM_Address), 64'(expAddr));
      checkOutput("misaligned", 64'(bus.oAGU_Misaligned), 64'(expMis));
    end
  end

  task automatic applyStimulus(input logic v, input logic [1:0] mode, input logic [1:0] sel,
                               input logic [DW-1:0] a, input logic [DW-1:0] b, input logic we,
                               input logic re, input logic [1:0] op, input logic [DW-1:0] sd);
    bus.iID_AGU_Valid = v;
    bus.iID_AGU_Mode = mode;
    bus.iID_AGU_Stream_Sel = sel;
    bus.iID_AGU_Operand_A = a;
    bus.iID_AGU_Operand_B = b;
    bus.iID_AGU_Memory_Write_Enable = we;
    bus.iID_AGU_Memory_Read_Enable = re;
    bus.iID_AGU_Memory_Opcode = op;
    bus.iID_AGU_Memory_Store_Data = sd;
  endtask

  task automatic applyConfig(input logic en, input logic [1:0] sel, input logic [1:0] field, input logic [DW-1:0] data);
    bus.iCfg_Write_Enable = en;
    bus.iCfg_Stream_Sel = sel;
    bus.iCfg_Field = field;
    bus.iCfg_Data = data;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyConfig(0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    bus.iStall = 0;
    idle();
    repeat (3) tick();
    checkOutput("resetValid", 64'(bus.oAGU_DMEM_Valid), 64'd0);
    checkOutput("resetAddr", 64'(bus.oAGU_DMEM_Address), 64'd0);
    checkOutput("resetByteSel", 64'(bus.oAGU_DMEM_Byte_Select), 64'd0);
    checkOutput("resetData", 64'(bus.oAGU_DMEM_Memory_Store_Data), 64'd0);
    rstN = 1;
    cmpEn = 1;

    // Base+offset half store.
    applyStimulus(1, 0, 0, 32'h100, 32'h6, 1, 0, 2'd1, 32'hABCD1234);
    tick();
    checkOutput("t1Addr", 64'(bus.oAGU_DMEM_Address), 64'h106);
    checkOutput("t1ByteSel", 64'(bus.oAGU_DMEM_Byte_Select), 64'hC);
    checkOutput("t1Data", 64'(bus.oAGU_DMEM_Memory_Store_Data), 64'h12341234);
    checkOutput("t1Valid", 64'(bus.oAGU_DMEM_Valid), 64'd1);
    checkOutput("t1ModelAddr", 64'(expAddr), 64'h106);
    checkOutput("t1ModelData", 64'(expData), 64'h12341234);
    idle();

    // Circular stream 1: base 0x40, stride 4, limit 0x50.
    applyConfig(1, 1, 2'd0, 32'h40); tick();
    applyConfig(1, 1, 2'd1, 32'h4);  tick();
    applyConfig(1, 1, 2'd2, 32'h50); tick();
    applyConfig(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 2'd2, 1, 0, 0, 0, 1, 2'd2, 0);
      tick();
      checkOutput("t2CircAddr", 64'(bus.oAGU_DMEM_Address), 64'(circExp[i]));
      checkOutput("t2ByteSel", 64'(bus.oAGU_DMEM_Byte_Select), 64'hF);
    end
    idle();

    // Post-increment on stream 0 held by a three-cycle stall.
    applyConfig(1, 0, 2'd0, 32'h80); tick();
    applyConfig(1, 0, 2'd1, 32'h10); tick();
    applyConfig(0, 0, 0, 0);
    bus.iStall = 1;
    applyStimulus(1, 2'd1, 0, 0, 0, 0, 1, 2'd2, 0);
    repeat (3) begin
      tick();
      checkOutput("t3HeldAddr", 64'(bus.oAGU_DMEM_Address), 64'h40);
      checkOutput("t3HeldValid", 64'(bus.oAGU_DMEM_Valid), 64'd0);
    end
    bus.iStall = 0;
    tick();
    checkOutput("t3Addr", 64'(bus.oAGU_DMEM_Address), 64'h80);
    checkOutput("t3Read", 64'(bus.oAGU_DMEM_Memory_Read_Enable), 64'd1);
    tick();
    checkOutput("t3OneStep", 64'(bus.oAGU_DMEM_Address), 64'h90);
    idle();

    // Same-cycle pointer config write and stream 2 access: config wins.
    applyConfig(1, 2, 2'd0, 32'h10); tick();
    applyConfig(1, 2, 2'd1, 32'h8);  tick();
    applyConfig(1, 2, 2'd3, 32'h200);
    applyStimulus(1, 2'd1, 2, 0, 0, 0, 1, 2'd2, 0);
    tick();
    checkOutput("t4Addr", 64'(bus.oAGU_DMEM_Address), 64'h10);
    applyConfig(0, 0, 0, 0);
    tick();
    checkOutput("t4CfgWins", 64'(bus.oAGU_DMEM_Address), 64'h200);
    idle();

    // Misaligned word store at 0x102.
    applyStimulus(1, 0, 0, 32'h100, 32'h2, 1, 0, 2'd2, 32'hCAFEF00D);
    tick();
    checkOutput("t5Addr", 64'(bus.oAGU_DMEM_Address), 64'h102);
    checkOutput("t5Valid", 64'(bus.oAGU_DMEM_Valid), 64'd1);
`ifdef PE_AGU_MISALIGN_TRAP_EN
    checkOutput("t5Mis", 64'(bus.oAGU_Misaligned), 64'd1);
    checkOutput("t5We", 64'(bus.oAGU_DMEM_Memory_Write_Enable), 64'd0);
`else
    checkOutput("t5ByteSel", 64'(bus.oAGU_DMEM_Byte_Select), 64'hF);
    checkOutput("t5Mis", 64'(bus.oAGU_Misaligned), 64'd0);
    checkOutput("t5We", 64'(bus.oAGU_DMEM_Memory_Write_Enable), 64'd1);
`endif

    // Dword on a 32-bit bus is illegal.
    applyStimulus(1, 0, 0, 32'h200, 32'h0, 1, 0, 2'd3, 32'h1);
    tick();
    checkOutput("t6ByteSel", 64'(bus.oAGU_DMEM_Byte_Select), 64'd0);
    checkOutput("t6We", 64'(bus.oAGU_DMEM_Memory_Write_Enable), 64'd0);
    checkOutput("t6Valid", 64'(bus.oAGU_DMEM_Valid), 64'd1);

    // Reset asserted while stalled clears outputs at once and all pointers.
    applyStimulus(1, 0, 0, 32'h300, 32'h4, 0, 1, 2'd2, 0);
    tick();
    bus.iStall = 1;
    tick();
    #4;
    rstN = 0;
    #1;
    checkOutput("t7Valid", 64'(bus.oAGU_DMEM_Valid), 64'd0);
    checkOutput("t7Addr", 64'(bus.oAGU_DMEM_Address), 64'd0);
    checkOutput("t7Read", 64'(bus.oAGU_DMEM_Memory_Read_Enable), 64'd0);
    idle();
    bus.iStall = 0;
    tick();
    rstN = 1;
    applyStimulus(1, 2'd1, 1, 0, 0, 0, 1, 2'd2, 0);
    tick();
    checkOutput("t7Ptr1", 64'(bus.oAGU_DMEM_Address), 64'd0);
    applyStimulus(1, 2'd1, 2, 0, 0, 0, 1, 2'd2, 0);
    tick();
    checkOutput("t7Ptr2", 64'(bus.oAGU_DMEM_Address), 64'd0);
    idle();

    // Randomized traffic; the compare process checks every cycle.
    for (int c = 0; c < 600; c++) begin
      bus.iStall = ($urandom_range(0, 4) == 0);
      applyStimulus($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)), $urandom);
      if ($urandom_range(0, 5) == 0)
        applyConfig(1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 32'($urandom_range(0, 32'h400)));
      else
        applyConfig(0, 0, 0, 0);
      tick();
    end
    bus.iStall = 0;
    idle();
    tick();
    tick();
    cmpEn = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
